// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: FSM states and the
// oversampling ratios the receiver understands.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8       = 6'd8;
  localparam logic [5:0] PRESCALE_16      = 6'd16;
  localparam logic [5:0] PRESCALE_32      = 6'd32;
  localparam logic [5:0] PRESCALE_DEFAULT = PRESCALE_8;

  // Unsupported ratios fall back to the default so counters always wrap sanely.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Takes three samples around mid-bit and registers their 2-of-3 majority,
// which is valid from the cycle after the third sample onward.
module uart_rx_data_sampler (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic [5:0] edge_cnt_i,
  input  logic [5:0] prescale_i,
  output logic       bit_o
);

  logic [5:0] mid;
  logic       s0_q;
  logic       s1_q;
  logic       maj_q;

  assign mid   = prescale_i >> 1;
  assign bit_o = maj_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
      maj_q <= 1'b1;
    end else begin
      if (edge_cnt_i == mid - 6'd1) s0_q <= rx_i;
      if (edge_cnt_i == mid)        s1_q <= rx_i;
      if (edge_cnt_i == mid + 6'd1) maj_q <= (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: start detection, mid-bit voted sampling, LSB-first
// deserialization, optional parity and stop-bit checking.
module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  BUSY
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state_q;
  logic [5:0]            edge_cnt_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic [5:0]            presc_q;
  logic [5:0]            presc_d;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_err_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  dv_q;
  logic                  pe_q;
  logic                  se_q;
  logic                  sample;
  logic                  decide;
  logic                  last_edge;

  assign presc_d   = legal_prescale(PRESCALE);
  assign decide    = edge_cnt_q == (presc_q >> 1) + 6'd2;
  assign last_edge = edge_cnt_q == presc_q - 6'd1;

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;
  assign BUSY       = state_q != IDLE;

  uart_rx_data_sampler u_sampler (
    .clk_i      (CLK),
    .rst_i      (RST),
    .rx_i       (RX_IN),
    .edge_cnt_i (edge_cnt_q),
    .prescale_i (presc_q),
    .bit_o      (sample)
  );

  // The detect cycle counts as edge 0 of the start bit, so START begins at 1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      presc_q    <= PRESCALE_DEFAULT;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err_q  <= 1'b0;
      data_q     <= '0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!RX_IN) begin
            state_q    <= START;
            edge_cnt_q <= 6'd1;
            bit_cnt_q  <= '0;
            presc_q    <= presc_d;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            par_err_q  <= 1'b0;
          end
        end
        START: begin
          if (decide && sample) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
          end else if (last_edge) begin
            state_q    <= DATA;
            edge_cnt_q <= '0;
          end else begin
            edge_cnt_q <= edge_cnt_q + 6'd1;
          end
        end
        DATA: begin
          if (decide) data_q <= DATA_WIDTH'({sample, data_q} >> 1);
          if (last_edge) begin
            edge_cnt_q <= '0;
            if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
          end else begin
            edge_cnt_q <= edge_cnt_q + 6'd1;
          end
        end
        PARITY: begin
          if (decide) par_err_q <= sample != ((^data_q) ^ par_typ_q);
          if (last_edge) begin
            state_q    <= STOP;
            edge_cnt_q <= '0;
          end else begin
            edge_cnt_q <= edge_cnt_q + 6'd1;
          end
        end
        // Leave half a bit early so a following start bit is not missed.
        STOP: begin
          if (decide) begin
            dv_q       <= sample & ~par_err_q;
            pe_q       <= par_err_q;
            se_q       <= ~sample;
            if (sample && !par_err_q) p_data_q <= data_q;
            state_q    <= sample ? IDLE : WAIT_IDLE;
            edge_cnt_q <= '0;
          end else begin
            edge_cnt_q <= edge_cnt_q + 6'd1;
          end
        end
        WAIT_IDLE: begin
          if (RX_IN) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: builds a per-cycle line waveform, predicts outputs from
// the UART framing rules, and compares every cycle plus key frame timings.
module tb_uart_rx_deserializer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         RX_IN;
  logic [5:0]   PRESCALE;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_ERR;
  logic         STP_ERR;
  logic         BUSY;

  int vectors = 0;
  int miscompares = 0;

  bit           lineQ[$];
  bit           rstQ[$];
  bit           penQ[$];
  bit           ptyQ[$];
  logic [5:0]   preQ[$];
  logic [W+3:0] obsV[];
  logic [W+3:0] expV[];
  logic [W-1:0] curPData = '0;

  uart_rx_deserializer #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic int legalP(logic [5:0] p);
    return (p == 6'd16 || p == 6'd32) ? int'(p) : 8;
  endfunction

  function automatic bit lineAt(int pos);
    return (pos < lineQ.size()) ? lineQ[pos] : 1'b1;
  endfunction

  function automatic bit voteAt(int centre);
    bit a, b, c;
    a = lineAt(centre - 1);
    b = lineAt(centre);
    c = lineAt(centre + 1);
    return (a & b) | (a & c) | (b & c);
  endfunction

  task automatic clearStim();
    lineQ.delete(); rstQ.delete(); penQ.delete(); ptyQ.delete(); preQ.delete();
  endtask

  task automatic pushCycle(bit l, bit r, logic [5:0] p, bit pe, bit pt);
    lineQ.push_back(l); rstQ.push_back(r); preQ.push_back(p);
    penQ.push_back(pe); ptyQ.push_back(pt);
  endtask

  // Configuration inputs wander randomly except on a frame's first cycle.
  task automatic pushLevel(bit l, int n);
    repeat (n) pushCycle(l, 1'b0, 6'($urandom_range(0, 63)), 1'($urandom), 1'($urandom));
  endtask

  task automatic appendFrame(logic [5:0] pin, bit pe, bit pt, logic [W-1:0] d, bit pbit, bit stop);
    int p;
    bit bits[$];
    p = legalP(pin);
    bits.push_back(1'b0);
    for (int k = 0; k < W; k++) bits.push_back(d[k]);
    if (pe) bits.push_back(pbit);
    bits.push_back(stop);
    foreach (bits[b]) begin
      for (int c = 0; c < p; c++) begin
        if (b == 0 && c == 0) pushCycle(bits[b], 1'b0, pin, pe, pt);
        else pushCycle(bits[b], 1'b0, 6'($urandom_range(0, 63)), 1'($urandom), 1'($urandom));
      end
    end
  endtask

  // Reference model: scan the waveform as a receiver would, frame by frame.
  task automatic runModel();
    int n, i, p, h, nb, endc, r, j;
    bit glitch, pen, pt, perr, stop;
    logic [W-1:0] d, cur;
    bit busyA[], dvA[], peA[], seA[], rstAt[], newAt[];
    logic [W-1:0] newVal[];
    n = lineQ.size();
    expV = new[n];
    busyA = new[n]; dvA = new[n]; peA = new[n]; seA = new[n];
    rstAt = new[n]; newAt = new[n]; newVal = new[n];
    i = 0;
    while (i < n) begin
      if (rstQ[i]) begin
        if (i + 1 < n) rstAt[i+1] = 1'b1;
        i++;
        continue;
      end
      if (lineQ[i]) begin
        i++;
        continue;
      end
      p = legalP(preQ[i]); h = p / 2; pen = penQ[i]; pt = ptyQ[i];
      glitch = voteAt(i + h);
      nb = 2 + W + (pen ? 1 : 0);
      endc = glitch ? i + h + 2 : i + (nb - 1) * p + h + 2;
      r = -1;
      for (int k = i + 1; k <= endc && k < n; k++) begin
        if (rstQ[k]) begin r = k; break; end
      end
      if (r >= 0) begin
        for (int k = i + 1; k <= r; k++) busyA[k] = 1'b1;
        if (r + 1 < n) rstAt[r+1] = 1'b1;
        i = r + 1;
        continue;
      end
      for (int k = i + 1; k <= endc && k < n; k++) busyA[k] = 1'b1;
      if (glitch) begin
        i = endc + 1;
        continue;
      end
      for (int k = 0; k < W; k++) d[k] = voteAt(i + (k + 1) * p + h);
      perr = pen && (voteAt(i + (W + 1) * p + h) != ((^d) ^ pt));
      stop = voteAt(i + (nb - 1) * p + h);
      if (endc + 1 < n) begin
        dvA[endc+1] = !perr && stop;
        peA[endc+1] = perr;
        seA[endc+1] = !stop;
        if (!perr && stop) begin newAt[endc+1] = 1'b1; newVal[endc+1] = d; end
      end
      if (stop) begin
        i = endc + 1;
      end else begin
        j = endc + 1;
        while (j < n && !lineQ[j] && !rstQ[j]) begin busyA[j] = 1'b1; j++; end
        if (j < n) begin
          busyA[j] = 1'b1;
          if (rstQ[j] && j + 1 < n) rstAt[j+1] = 1'b1;
        end
        i = j + 1;
      end
    end
    cur = curPData;
    for (int c = 0; c < n; c++) begin
      if (rstAt[c]) cur = '0;
      if (newAt[c]) cur = newVal[c];
      expV[c] = {busyA[c], dvA[c], peA[c], seA[c], cur};
    end
    curPData = cur;
  endtask

  // Plays one waveform cycle per clock; obsV[c] is the output state during cycle c.
  task automatic applyStimulus();
    obsV = new[lineQ.size()];
    for (int c = 0; c < lineQ.size(); c++) begin
      @(posedge CLK);
      #1;
      obsV[c] = {BUSY, DATA_VALID, PAR_ERR, STP_ERR, P_DATA};
      RX_IN = lineQ[c]; RST = rstQ[c]; PRESCALE = preQ[c];
      PAR_EN = penQ[c]; PAR_TYP = ptyQ[c];
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", BUSY); end
    vectors++;
    if (DATA_VALID !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dv got %b want 0", DATA_VALID); end
    vectors++;
    if (PAR_ERR !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pe got %b want 0", PAR_ERR); end
    vectors++;
    if (STP_ERR !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_se got %b want 0", STP_ERR); end
    vectors++;
    if (P_DATA !== '0) begin miscompares++; $display("[TB] FAIL reset_pdata got %h want 00", P_DATA); end
    RST = 1'b0;
    curPData = '0;
  endtask

  task automatic test_basic();
    int s;
    clearStim(); pushLevel(1'b1, 4);
    s = lineQ.size();
    appendFrame(6'd8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
    pushLevel(1'b1, 20);
    runModel(); applyStimulus();
    vectors++;
    if (obsV[s+79] !== {4'b0100, 8'hA5}) begin
      miscompares++; $display("[TB] FAIL basic_pulse79 got %h want %h", obsV[s+79], {4'b0100, 8'hA5});
    end
    vectors++;
    if (obsV[s+78][W+2] !== 1'b0 || obsV[s+80][W+2] !== 1'b0) begin
      miscompares++; $display("[TB] FAIL basic_pulse_width got %b%b want 00", obsV[s+78][W+2], obsV[s+80][W+2]);
    end
    for (int c = 0; c < obsV.size(); c++) begin
      vectors++;
      if (obsV[c] !== expV[c]) begin miscompares++; $display("[TB] FAIL basic cyc %0d got %h want %h", c, obsV[c], expV[c]); end
    end
  endtask

  task automatic test_parity();
    int s1, s2, s3;
    clearStim(); pushLevel(1'b1, 3);
    s1 = lineQ.size(); appendFrame(6'd8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1); pushLevel(1'b1, 5);
    s2 = lineQ.size(); appendFrame(6'd8, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1); pushLevel(1'b1, 5);
    s3 = lineQ.size(); appendFrame(6'd8, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1);
    pushLevel(1'b1, 20);
    runModel(); applyStimulus();
    vectors++;
    if (obsV[s1+87] !== {4'b0100, 8'hA5}) begin
      miscompares++; $display("[TB] FAIL parity_even got %h want %h", obsV[s1+87], {4'b0100, 8'hA5});
    end
    vectors++;
    if (obsV[s2+87] !== {4'b0010, 8'hA5}) begin
      miscompares++; $display("[TB] FAIL parity_odd_err got %h want %h", obsV[s2+87], {4'b0010, 8'hA5});
    end
    vectors++;
    if (obsV[s3+87] !== {4'b0010, 8'hA5}) begin
      miscompares++; $display("[TB] FAIL parity_hold got %h want %h", obsV[s3+87], {4'b0010, 8'hA5});
    end
    for (int c = 0; c < obsV.size(); c++) begin
      vectors++;
      if (obsV[c] !== expV[c]) begin miscompares++; $display("[TB] FAIL parity cyc %0d got %h want %h", c, obsV[c], expV[c]); end
    end
  endtask

  task automatic test_glitch();
    int s, s2;
    clearStim(); pushLevel(1'b1, 3);
    s = lineQ.size();
    pushCycle(1'b0, 1'b0, 6'd16, 1'b0, 1'b0);
    pushLevel(1'b0, 1);
    pushLevel(1'b1, 30);
    s2 = lineQ.size(); appendFrame(6'd16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
    pushLevel(1'b1, 30);
    runModel(); applyStimulus();
    vectors++;
    if (obsV[s+1][W+3] !== 1'b1 || obsV[s+11][W+3] !== 1'b0) begin
      miscompares++; $display("[TB] FAIL glitch_busy got %b%b want 10", obsV[s+1][W+3], obsV[s+11][W+3]);
    end
    vectors++;
    if (obsV[s2+155] !== {4'b0100, 8'h3C}) begin
      miscompares++; $display("[TB] FAIL glitch_then_frame got %h want %h", obsV[s2+155], {4'b0100, 8'h3C});
    end
    for (int c = 0; c < obsV.size(); c++) begin
      vectors++;
      if (obsV[c] !== expV[c]) begin miscompares++; $display("[TB] FAIL glitch cyc %0d got %h want %h", c, obsV[c], expV[c]); end
    end
  endtask

  task automatic test_stop_error();
    int s;
    clearStim(); pushLevel(1'b1, 3);
    s = lineQ.size();
    appendFrame(6'd8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
    pushLevel(1'b0, 32);
    pushLevel(1'b1, 20);
    runModel(); applyStimulus();
    vectors++;
    if (obsV[s+79][W+3:W] !== 4'b1001) begin
      miscompares++; $display("[TB] FAIL stop_err_flags got %b want 1001", obsV[s+79][W+3:W]);
    end
    vectors++;
    if (obsV[s+112][W+3] !== 1'b1 || obsV[s+113][W+3] !== 1'b0) begin
      miscompares++; $display("[TB] FAIL stop_err_busy got %b%b want 10", obsV[s+112][W+3], obsV[s+113][W+3]);
    end
    for (int c = 0; c < obsV.size(); c++) begin
      vectors++;
      if (obsV[c] !== expV[c]) begin miscompares++; $display("[TB] FAIL stop_err cyc %0d got %h want %h", c, obsV[c], expV[c]); end
    end
  endtask

  task automatic test_back_to_back();
    int s, s3;
    clearStim(); pushLevel(1'b1, 3);
    s = lineQ.size();
    appendFrame(6'd32, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1);
    appendFrame(6'd32, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1);
    s3 = lineQ.size();
    appendFrame(6'd32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    rstQ[s3+100] = 1'b1;
    pushLevel(1'b1, 40);
    runModel(); applyStimulus();
    vectors++;
    if (obsV[s+307] !== {4'b0100, 8'h01}) begin
      miscompares++; $display("[TB] FAIL b2b_first got %h want %h", obsV[s+307], {4'b0100, 8'h01});
    end
    vectors++;
    if (obsV[s+627] !== {4'b0100, 8'hFE}) begin
      miscompares++; $display("[TB] FAIL b2b_second got %h want %h", obsV[s+627], {4'b0100, 8'hFE});
    end
    vectors++;
    if (obsV[s3+101] !== '0) begin
      miscompares++; $display("[TB] FAIL b2b_reset got %h want 000", obsV[s3+101]);
    end
    for (int c = 0; c < obsV.size(); c++) begin
      vectors++;
      if (obsV[c] !== expV[c]) begin miscompares++; $display("[TB] FAIL b2b cyc %0d got %h want %h", c, obsV[c], expV[c]); end
    end
  endtask

  task automatic test_random();
    logic [5:0] pin;
    logic [W-1:0] d;
    bit pe, pt, pbit, stop;
    int t, pos;
    clearStim(); pushLevel(1'b1, 5);
    for (int f = 0; f < 25; f++) begin
      case ($urandom_range(0, 3))
        0: pin = 6'd8;
        1: pin = 6'd16;
        2: pin = 6'd32;
        default: pin = 6'($urandom_range(0, 63));
      endcase
      pe = 1'($urandom); pt = 1'($urandom); d = W'($urandom);
      pbit = ((^d) ^ pt) ^ ($urandom_range(0, 4) == 0);
      stop = $urandom_range(0, 6) != 0;
      appendFrame(pin, pe, pt, d, pbit, stop);
      pushLevel(1'b1, $urandom_range(0, 4));
    end
    t = lineQ.size();
    for (int k = 0; k < 12; k++) begin
      pos = $urandom_range(0, t - 1);
      lineQ[pos] = ~lineQ[pos];
    end
    pushLevel(1'b1, 400);
    runModel(); applyStimulus();
    for (int c = 0; c < obsV.size(); c++) begin
      vectors++;
      if (obsV[c] !== expV[c]) begin miscompares++; $display("[TB] FAIL random cyc %0d got %h want %h", c, obsV[c], expV[c]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_stop_error();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

UART receive path: detects start bits on an oversampled serial line, majority-votes each bit at mid-bit, deserializes LSB-first data, and checks optional parity and the stop bit. It is the receive-side counterpart of the UART TX serializer and sits between the RX pad synchronizer and the RX data FIFO/synchronizer feeding the system controller. A frame's byte is presented with a one-cycle valid pulse only when the frame is error-free.

## Interface
- DATA_WIDTH, 8, data bits per frame
- CLK  in  1  receive oversampling clock; one clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- RX_IN  in  1  serial line, idle high, already synchronized upstream
- PRESCALE  in  6  oversampling ratio; legal 8, 16, 32; any other value treated as 8
- PAR_EN  in  1  1 = parity bit present after data
- PAR_TYP  in  1  0 = even, 1 = odd
- P_DATA  out  DATA_WIDTH  received byte, LSB first on line
- DATA_VALID  out  1  one-cycle pulse, P_DATA valid
- PAR_ERR  out  1  one-cycle pulse, parity mismatch
- STP_ERR  out  1  one-cycle pulse, stop bit sampled 0
- BUSY  out  1  high whenever state != IDLE

## Operation
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- PRESCALE, PAR_EN, PAR_TYP captured at start detection; mid-frame changes ignored.
- edge_cnt counts 0..P-1 within each bit (P = captured prescale); bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling: RX_IN sampled at edge_cnt = P/2-1, P/2, P/2+1; 2-of-3 majority registered; decision cycle is edge_cnt = P/2+2.
- IDLE: RX_IN = 0 -> START; the detect cycle is edge_cnt 0.
- START: decision 1 (glitch) -> IDLE immediately, no outputs; decision 0 -> DATA at edge_cnt = P-1.
- DATA: decided bit shifted in at MSB (LSB-first reception); after bit DATA_WIDTH-1 at edge_cnt = P-1 -> PARITY if PAR_EN else STOP.
- PARITY: expected = ^data XOR PAR_TYP; mismatch latched internally; -> STOP at edge_cnt = P-1.
- STOP: at decision cycle evaluate; P_DATA, DATA_VALID, PAR_ERR, STP_ERR registered; DATA_VALID = no parity error and stop = 1; error flags independent, both may pulse together. Then stop = 1 -> IDLE; stop = 0 -> WAIT_IDLE.
- WAIT_IDLE: stay until RX_IN = 1, then IDLE (no false start on a held-low line/break).
- P_DATA updated only on DATA_VALID; holds last good byte otherwise.

## Timing
- Reset: all outputs 0, P_DATA = 0, state IDLE, counters 0; reset mid-frame -> IDLE next cycle, no pulses.
- Frame bits N = 1 + DATA_WIDTH + PAR_EN + 1. With detect cycle = 0, stop decision at D = (N-1)*P + P/2+2; outputs visible at cycle D+1 for exactly one cycle.
- Return to IDLE half a bit early (at D+1) so back-to-back frames with zero idle are received.
- Start glitch shorter than P/2-1 cycles never produces a frame.

## Structure
- Package uart_rx_pkg: state enum, legal prescale constants (8/16/32), default-prescale constant.
- One sub-module: uart_rx_data_sampler (three-point sampling and majority vote, driven by edge_cnt and P); FSM, counters, deserializer and checks in the top.

## Test plan
- P=8, PAR_EN=0, byte 0xA5, stop 1 -> DATA_VALID=1 and P_DATA=0xA5 at cycle 79 only; errors 0.
- P=8, PAR_EN=1, PAR_TYP=0, 0xA5, parity bit 0 -> DATA_VALID at cycle 87, P_DATA=0xA5.
- P=8, PAR_EN=1, PAR_TYP=1, 0xA5, parity bit 0 -> PAR_ERR=1 at cycle 87, DATA_VALID=0, P_DATA unchanged.
- P=16, RX_IN low 2 cycles then high -> no outputs, BUSY drops at edge_cnt 10; then 0x3C frame received correctly.
- P=8, 0x55 with stop 0, line held low 40 cycles -> STP_ERR pulse, DATA_VALID=0, BUSY high until RX_IN=1, no spurious frame.
- P=32, frames 0x01, 0xFE back-to-back zero idle -> two DATA_VALID pulses 320 cycles apart; RST asserted mid-third frame -> IDLE, all outputs 0, no pulse.
